alu_issue_unit: RTL

- Upstream stage of the 8-bit ALU. It buffers incoming instructions in a small FIFO and holds an 8-entry x 8-bit register file.
- For each instruction it decodes the fields, reads the operands, drives the combinational ALU's opcode and input buses, and captures alu_output the following cycle.
- The captured result is written back to the destination register and reported on a result port.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/issue_fifo.sv | 58 +++++
 rtl/alu_issue_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: opcode encodings, instruction layout and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_EQ    = 4'h3;
  localparam logic [3:0] OP_GT    = 4'h4;
  localparam logic [3:0] OP_MOVE  = 4'hB;
  localparam logic [3:0] OP_LOADI = 4'hF;

  localparam int INSTR_WIDTH = 16;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] pad;
  } instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } issue_state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_EQ)  || (op == OP_GT)  || (op == OP_MOVE);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction FIFO; depth must be a power of two so the pointers wrap naturally.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Accept is gated by the registered full flag only, so a pop never frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the combinational 8-bit ALU: instruction FIFO, register file and issue FSM.
// Optional retired-instruction counter enabled by defining ALU_ISSUE_PERF_COUNTER_EN.
//   state | meaning
//   IDLE  | pop next instruction; issue ALU op, execute LOADI locally, or flag illegal
//   EXEC  | ALU inputs valid; capture alu_output_in and write it back
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [15:0]           instr_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  output logic [7:0]            alu_opcode_out,
  output logic [DATA_WIDTH-1:0] alu_input1_out,
  output logic [DATA_WIDTH-1:0] alu_input2_out,
  output logic                  alu_enable_out,
  input  logic [DATA_WIDTH-1:0] alu_output_in,
  output logic                  result_valid_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [2:0]            result_reg_out,
  output logic                  illegal_out,
  input  logic [2:0]            dbg_addr_in,
`ifdef ALU_ISSUE_PERF_COUNTER_EN
  output logic [DATA_WIDTH-1:0] dbg_data_out,
  output logic [15:0]           retired_count_out
`else
  output logic [DATA_WIDTH-1:0] dbg_data_out
`endif
);

  issue_state_t          state_q, state_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic                  enable_q, enable_d;
  logic [2:0]            rd_q, rd_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            rreg_q, rreg_d;
  logic                  illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [15:0]           fifo_head;
  instr_t                hd;
  logic                  reg_we;
  logic [2:0]            reg_waddr;
  logic [DATA_WIDTH-1:0] reg_wdata;

  issue_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(INSTR_WIDTH)
  ) u_fifo (
    .clk_i  (clock_in),
    .rst_i  (reset_in),
    .push_i (instr_valid_in),
    .data_i (instr_in),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  assign hd               = instr_t'(fifo_head);
  assign instr_ready_out  = !fifo_full;
  assign alu_opcode_out   = opcode_q;
  assign alu_input1_out   = in1_q;
  assign alu_input2_out   = in2_q;
  assign alu_enable_out   = enable_q;
  assign result_valid_out = rvalid_q;
  assign result_out       = result_q;
  assign result_reg_out   = rreg_q;
  assign illegal_out      = illegal_q;
  assign dbg_data_out     = regs_q[dbg_addr_in];

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    enable_d  = enable_q;
    rd_d      = rd_q;
    rvalid_d  = 1'b0;
    result_d  = result_q;
    rreg_d    = rreg_q;
    illegal_d = illegal_q;
    fifo_pop  = 1'b0;
    reg_we    = 1'b0;
    reg_waddr = rd_q;
    reg_wdata = alu_output_in;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_alu_op(hd.opcode)) begin
            opcode_d = {4'b0000, hd.opcode};
            in1_d    = regs_q[hd.rs1];
            in2_d    = regs_q[hd.rs2];
            enable_d = 1'b1;
            rd_d     = hd.rd;
            state_d  = EXEC;
          end else if (hd.opcode == OP_LOADI) begin
            reg_we    = 1'b1;
            reg_waddr = hd.rd;
            reg_wdata = DATA_WIDTH'(fifo_head[7:0]);
            rvalid_d  = 1'b1;
            result_d  = DATA_WIDTH'(fifo_head[7:0]);
            rreg_d    = hd.rd;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        // ALU buses are left untouched so they hold until the next issue.
        reg_we   = 1'b1;
        rvalid_d = 1'b1;
        result_d = alu_output_in;
        rreg_d   = rd_q;
        enable_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      enable_q  <= 1'b0;
      rd_q      <= '0;
      rvalid_q  <= 1'b0;
      result_q  <= '0;
      rreg_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      enable_q  <= enable_d;
      rd_q      <= rd_d;
      rvalid_q  <= rvalid_d;
      result_q  <= result_d;
      rreg_q    <= rreg_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_waddr] <= reg_wdata;
    end
  end

`ifdef ALU_ISSUE_PERF_COUNTER_EN
  logic [15:0] retired_q;

  always_ff @(posedge clock_in) begin
    if (reset_in)      retired_q <= '0;
    else if (rvalid_q) retired_q <= retired_q + 16'd1;
  end

  assign retired_count_out = retired_q;
`endif

endmodule
